// File: rtl/sbm_unsigned_pipe.sv
// Pipelined unsigned shift-and-add multiplier (W x W -> 2W) with valid/ready handshake and global stall.
// Define SBM_LEVEL_REG_EN to register every adder-tree level (latency 2+L instead of 2).
module sbm_unsigned_pipe #(
  parameter int W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     D,
  input  logic [W-1:0]     E,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   F
);
  localparam int L = (W <= 1) ? 0 : $clog2(W);
  localparam int P = 2 * W;

  logic           adv;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           v0;
  logic [P-1:0]   pp [0:W-1];
  logic [P-1:0]   tree_out;
  logic           v_last;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v0  <= 1'b0;
    end else if (adv) begin
      a_q <= D;
      b_q <= E;
      v0  <= in_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_pp
      assign pp[gi] = {{W{1'b0}}, a_q & {W{b_q[gi]}}} << gi;
    end
  endgenerate

`ifdef SBM_LEVEL_REG_EN
  localparam int LM = (L > 0) ? L : 1;

  // lvl_q[k] holds the result of tree level k+1; only the first ceil(W/2^(k+1)) slots are live.
  logic [P-1:0] lvl_q [0:LM-1][0:W-1];
  logic [P-1:0] lvl_d [0:LM-1][0:W-1];
  logic [LM-1:0] lv_q;

  always_comb begin
    int n;
    int i0;
    int i1;
    int km;
    logic [P-1:0] s0;
    logic [P-1:0] s1;
    n = W;
    for (int k = 0; k < LM; k++) begin
      for (int j = 0; j < W; j++) begin
        lvl_d[k][j] = '0;
      end
    end
    for (int k = 0; k < L; k++) begin
      km = (k > 0) ? k - 1 : 0;
      for (int j = 0; j < W; j++) begin
        i0 = (2 * j < W) ? 2 * j : 0;
        i1 = (2 * j + 1 < W) ? 2 * j + 1 : 0;
        s0 = (k == 0) ? pp[i0] : lvl_q[km][i0];
        s1 = (k == 0) ? pp[i1] : lvl_q[km][i1];
        if (2 * j + 1 < n)
          lvl_d[k][j] = s0 + s1;
        else if (2 * j < n)
          lvl_d[k][j] = s0;
      end
      n = (n + 1) / 2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LM; k++) begin
        lv_q[k] <= 1'b0;
        for (int j = 0; j < W; j++) begin
          lvl_q[k][j] <= '0;
        end
      end
    end else if (adv) begin
      lvl_q <= lvl_d;
      for (int k = 0; k < LM; k++) begin
        lv_q[k] <= (k == 0) ? v0 : lv_q[(k > 0) ? k - 1 : 0];
      end
    end
  end

  generate
    if (L == 0) begin : g_no_tree
      assign tree_out = pp[0];
      assign v_last   = v0;
    end else begin : g_tree
      assign tree_out = lvl_q[L-1][0];
      assign v_last   = lv_q[L-1];
    end
  endgenerate
`else
  logic [P-1:0] cur [0:W-1];

  // In-place reduction: slot j of a level only reads slots 2j and 2j+1, which are not yet overwritten.
  always_comb begin
    int n;
    n   = W;
    cur = pp;
    for (int k = 0; k < L; k++) begin
      for (int j = 0; j < W; j++) begin
        if (2 * j + 1 < n)
          cur[j] = cur[(2 * j < W) ? 2 * j : 0] + cur[(2 * j + 1 < W) ? 2 * j + 1 : 0];
        else if (2 * j < n)
          cur[j] = cur[(2 * j < W) ? 2 * j : 0];
        else
          cur[j] = '0;
      end
      n = (n + 1) / 2;
    end
  end

  assign tree_out = cur[0];
  assign v_last   = v0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      F         <= '0;
    end else if (adv) begin
      out_valid <= v_last;
      if (v_last)
        F <= tree_out;
    end
  end

endmodule

// File: tb/tb_sbm_unsigned_pipe.sv
// Directed bench for sbm_unsigned_pipe: W=10 function, latency, backpressure, reset; W=1/3/5 full sweeps.
module tb_sbm_unsigned_pipe;
`ifdef SBM_LEVEL_REG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [9:0] d, e;
  logic [19:0] f;

  logic       iv1, ir1, ov1;
  logic [0:0] d1, e1;
  logic [1:0] f1;
  logic       iv3, ir3, ov3;
  logic [2:0] d3, e3;
  logic [5:0] f3;
  logic       iv5, ir5, ov5;
  logic [4:0] d5, e5;
  logic [9:0] f5;

  int n_cmp = 0;
  int n_bad = 0;

  sbm_unsigned_pipe #(.W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .D(d), .E(e),
    .out_valid(out_valid), .out_ready(out_ready), .F(f));
  sbm_unsigned_pipe #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .D(d1), .E(e1),
    .out_valid(ov1), .out_ready(1'b1), .F(f1));
  sbm_unsigned_pipe #(.W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .D(d3), .E(e3),
    .out_valid(ov3), .out_ready(1'b1), .F(f3));
  sbm_unsigned_pipe #(.W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .D(d5), .E(e5),
    .out_valid(ov5), .out_ready(1'b1), .F(f5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, got, gaps, w;
    int exp_q[$];
    int got_q[$];
    int q1[$], q3[$], q5[$];
    int cnt1, cnt3, cnt5, last1, last3, last5;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; d = '0; e = '0;
    iv1 = 1'b0; d1 = '0; e1 = '0;
    iv3 = 1'b0; d3 = '0; e3 = '0;
    iv5 = 1'b0; d5 = '0; e5 = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_F", 64'(f), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Latency: the accepting edge is counted as cycle 1.
    d = 10'd1023; e = 10'd1023; in_valid = 1'b1;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      tick;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("max_product", 64'(f), 64'd1046529);
    tick;
    chk("single_valid_cycle", 64'(out_valid), 64'd0);

    d = 10'd0; e = 10'd777; in_valid = 1'b1;
    w = 0;
    tick;
    in_valid = 1'b0;
    while (!out_valid && w < 20) begin
      tick;
      w++;
    end
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_product", 64'(f), 64'd0);
    tick;

    // Back-to-back stream of 50 random pairs.
    got = 0; gaps = 0;
    for (int c = 0; c < 50 + LAT + 10; c++) begin
      if (c < 50) begin
        d = 10'($urandom_range(1023));
        e = 10'($urandom_range(1023));
        in_valid = 1'b1;
        exp_q.push_back(int'(d) * int'(e));
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stream_extra", 64'd1, 64'd0);
        else chk("stream_F", 64'(f), 64'(exp_q.pop_front()));
        got++;
      end else if (got > 0 && got < 50) begin
        gaps++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'd50);
    chk("stream_gaps", 64'(gaps), 64'd0);

    // Backpressure: two pairs enter, the first is held at the output.
    out_ready = 1'b0;
    d = 10'd1023; e = 10'd1023; in_valid = 1'b1;
    tick;
    d = 10'd3; e = 10'd5;
    tick;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      tick;
      w++;
    end
    chk("bp_arrive", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_F", 64'(f), 64'd1046529);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) got_q.push_back(int'(f));
      tick;
    end
    chk("bp_resume_count", 64'(got_q.size()), 64'd2);
    chk("bp_resume_first", 64'((got_q.size() > 0) ? got_q[0] : -1), 64'd1046529);
    chk("bp_resume_second", 64'((got_q.size() > 1) ? got_q[1] : -1), 64'd15);

    // Reset mid-flight; the pair presented alongside rst must be refused.
    d = 10'd11; e = 10'd13; in_valid = 1'b1;
    tick;
    d = 10'd17; e = 10'd19;
    tick;
    d = 10'd23; e = 10'd29;
    tick;
    d = 10'd2; e = 10'd2; rst = 1'b1;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_F", 64'(f), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    got_q.delete();
    d = 10'd5; e = 10'd7; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      in_valid = 1'b0;
      if (out_valid) got_q.push_back(int'(f));
    end
    chk("midrst_count", 64'(got_q.size()), 64'd1);
    chk("midrst_product", 64'((got_q.size() > 0) ? got_q[0] : -1), 64'd35);

    // Exhaustive sweeps of narrow widths, streamed in parallel; last pair is all-ones squared.
    cnt1 = 0; cnt3 = 0; cnt5 = 0; last1 = -1; last3 = -1; last5 = -1;
    for (int c = 0; c < 1024 + LAT + 10; c++) begin
      if (c < 4) begin
        {d1, e1} = c[1:0]; iv1 = 1'b1; q1.push_back(int'(d1) * int'(e1));
      end else iv1 = 1'b0;
      if (c < 64) begin
        {d3, e3} = c[5:0]; iv3 = 1'b1; q3.push_back(int'(d3) * int'(e3));
      end else iv3 = 1'b0;
      if (c < 1024) begin
        {d5, e5} = c[9:0]; iv5 = 1'b1; q5.push_back(int'(d5) * int'(e5));
      end else iv5 = 1'b0;
      tick;
      if (ov1) begin
        if (q1.size() == 0) chk("w1_extra", 64'd1, 64'd0);
        else chk("w1_F", 64'(f1), 64'(q1.pop_front()));
        last1 = int'(f1); cnt1++;
      end
      if (ov3) begin
        if (q3.size() == 0) chk("w3_extra", 64'd1, 64'd0);
        else chk("w3_F", 64'(f3), 64'(q3.pop_front()));
        last3 = int'(f3); cnt3++;
      end
      if (ov5) begin
        if (q5.size() == 0) chk("w5_extra", 64'd1, 64'd0);
        else chk("w5_F", 64'(f5), 64'(q5.pop_front()));
        last5 = int'(f5); cnt5++;
      end
    end
    chk("w1_count", 64'(cnt1), 64'd4);
    chk("w1_last", 64'(last1), 64'd1);
    chk("w3_count", 64'(cnt3), 64'd64);
    chk("w3_last", 64'(last3), 64'd49);
    chk("w5_count", 64'(cnt5), 64'd1024);
    chk("w5_last", 64'(last5), 64'd961);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sbm_unsigned_pipe.md
# sbm_unsigned_pipe

Parametrised, pipelined unsigned schoolbook (shift-and-add) multiplier producing a full-width `2W`-bit product. It generates `W` AND-gated partial products and reduces them with a binary adder tree, odd operands passing through to the next level. A valid/ready handshake on both sides with global stall lets it sit directly in the streaming datapath of the Montgomery multiplier, as the generic successor of the fixed-width, handshake-less schoolbook multipliers.

## Interface

Parameters:
- `W`, default 10: operand width, legal range 1..128.
- `L`: tree depth, ceil(log2(W)), 0 when W=1. Derived locally; not overridable.

Ports:
- `clk`, input, 1: clock; all state updates on rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `in_valid`, input, 1: D/E carry an operand pair.
- `in_ready`, output, 1: block accepts a pair this cycle.
- `D`, input, W: multiplicand, unsigned.
- `E`, input, W: multiplier, unsigned.
- `out_valid`, output, 1: F holds a product not yet consumed.
- `out_ready`, input, 1: downstream consumes F this cycle.
- `F`, output, 2W: product D*E, registered.

## Operation

- Global advance: `adv = !out_valid || out_ready`. `in_ready = adv`, combinational; no other input feeds it.
- Input accepted when `in_valid && in_ready`.
- Stage 0 (input regs `a_q`, `b_q`, `v0`): on `adv`, load D, E, and in_valid.
- Partial product `pp_i = (a_q & {W{b_q[i]}}) << i`, zero-extended to 2W bits, for i = 0..W-1.
- Tree level k pairs adjacent terms (0+1, 2+3, ...). An odd last term passes through unchanged. All sums are 2W bits wide; no overflow is possible, and no bits are truncated.
- Output stage: on `adv`, `out_valid <= v_last`. F loads the tree result only when `v_last`; otherwise F holds its previous value.
- Stall (`!adv`): every register, valid bits included, holds. Bubbles inside the pipe are not squeezed out.
- Products leave strictly in acceptance order. None is dropped or duplicated.
- Reset: all valid bits are 0, `out_valid` = 0, `F` = 0, and `a_q`/`b_q`/level registers are 0. `in_ready` = 1 in the first cycle after reset.
- `rst` asserted mid-operation discards all in-flight pairs. A pair presented in the same cycle as `rst` is not accepted; `rst` has priority over `adv`.

## Timing

- Latency is counted from the accepting edge to the edge at which `out_valid` rises with that product, with no stall.
  - Without `SBM_LEVEL_REG_EN`: 2 cycles (input reg, output reg).
  - With it: 2+L cycles. For W=10 (L=4) that is 6.
- Throughput: 1 product per cycle while `out_ready` is held high.
- Each stall cycle adds exactly one cycle to the latency of every in-flight pair.
- F and `out_valid` are stable while `out_valid && !out_ready`.
- Pipeline occupancy: at most 2 pairs without the macro, at most 2+L with it.

## Configuration

- `SBM_LEVEL_REG_EN` defined:
  - A register stage, data plus valid bit, sits after every tree level.
  - Every register stage is enabled by `adv` and cleared by `rst`.
  - Critical path is one 2W-bit adder.
- Not defined:
  - The tree is purely combinational between stage 0 and the output register.
  - Latency is 2, identical to the legacy fixed multipliers.
- Functional results and ordering are identical in both builds; only latency and occupancy differ.

## Test plan

- W=10, out_ready=1, single pair D=1023, E=1023: `F` = 1046529 with `out_valid` high for one cycle, at latency 2 (macro off) or 6 (macro on). D=0, E=777 gives F=0.
- W=10 back-to-back stream of 50 random pairs with in_valid=1 and out_ready=1: 50 consecutive valid outputs, each equal to D*E, in order, no gaps.
- Backpressure with W=10:
  - Drop `out_ready` for 5 cycles while F=1046529 is valid: F and `out_valid` hold, and `in_ready` is 0 throughout.
  - Raise `out_ready`: the stream resumes with no loss or duplication.
- Reset mid-flight with W=10 and macro on:
  - Accept 3 pairs, then assert `rst` for 1 cycle: next cycle `out_valid` = 0, F = 0, `in_ready` = 1.
  - None of the 3 products ever appears.
  - A new pair 5*7 then yields F=35.
- Odd/edge widths, each swept over all operand pairs:
  - W=1: 1*1 gives F=1.
  - W=3: 7*7 gives F=49.
  - W=5: 31*31 gives F=961.
